// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Streaming RISC-V instruction encoder. It takes decoded fields (opcode,
// funct3, register indices, a sign-extended immediate and an immsrc format
// code) and packs them into a 32-bit instruction word. Each word is tagged
// with a byte address for writing into instruction memory. The datapath is a
// two-stage valid/ready pipeline: stage 1 holds the accepted fields and
// stage 2 holds the encoded word and its error flag.
//
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that the
// selected format cannot represent exactly. Without it, out_err only reports
// an illegal immsrc code.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   flush      synchronous pipeline clear (address counter untouched)
//   in_valid   input fields valid          in_ready   encoder can accept
//   immsrc     000 I, 001 S, 010 B, 011 J, 100 U, others illegal
//   imm        sign-extended immediate (U: full 32-bit value)
//   opcode, funct3, rd, rs1, rs2   instruction fields
//   addr_load  load the address counter   addr_in    value to load
//   out_valid  output word valid           out_ready  consumer accepts
//   out_instr  encoded instruction         out_addr   byte address of word
//   out_err    immediate not representable or illegal immsrc
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        immsrc,
    input  logic [31:0]       imm,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              s1_valid;
    logic [2:0]        s1_immsrc;
    logic [31:0]       s1_imm;
    logic [6:0]        s1_opcode;
    logic [2:0]        s1_funct3;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;

    logic              s2_valid;
    logic [31:0]       s2_instr;
    logic              s2_err;

    logic [ADDR_W-1:0] addr_q;

    logic              out_hs;
    logic              s1_adv;
    logic              accept;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              range_err;

    // Stage 1 may move forward whenever stage 2 is empty or is draining this
    // cycle, so a full pipeline still sustains one word per clock.
    assign out_hs   = s2_valid && out_ready;
    assign s1_adv   = !s2_valid || out_hs;
    assign in_ready = !reset && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;

    // Bit packing for each immediate format. Fields a format does not use are
    // simply left out of its concatenation.
    always_comb begin
        enc_word    = NOP;
        enc_illegal = 1'b0;
        case (s1_immsrc)
            3'b000: enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            3'b001: enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                                s1_imm[4:0], s1_opcode};
            3'b010: enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                s1_imm[4:1], s1_imm[11], s1_opcode};
            3'b011: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                                s1_imm[19:12], s1_rd, s1_opcode};
            3'b100: enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
            default: begin
                enc_word    = NOP;
                enc_illegal = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits a signed N-bit field exactly when every bit above the
    // field's sign bit matches it; B and J offsets must also be even, and a
    // U immediate must have nothing in its low 12 bits.
    always_comb begin
        range_err = 1'b0;
        case (s1_immsrc)
            3'b000, 3'b001: range_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            3'b010:         range_err = !((&s1_imm[31:12]) || !(|s1_imm[31:12]))
                                        || s1_imm[0];
            3'b011:         range_err = !((&s1_imm[31:20]) || !(|s1_imm[31:20]))
                                        || s1_imm[0];
            3'b100:         range_err = |s1_imm[11:0];
            default:        range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Pipeline registers. Flush empties both stages and drops whatever is
    // offered in the same cycle; stage 1 keeps its fields when stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_immsrc <= '0;
            s1_imm    <= '0;
            s1_opcode <= '0;
            s1_funct3 <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s2_valid  <= 1'b0;
            s2_instr  <= '0;
            s2_err    <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_instr <= enc_word;
                    s2_err   <= enc_illegal || range_err;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_immsrc <= immsrc;
                s1_imm    <= imm;
                s1_opcode <= opcode;
                s1_funct3 <= funct3;
                s1_rd     <= rd;
                s1_rs1    <= rs1;
                s1_rs2    <= rs2;
            end
        end
    end

    // Address counter. A load takes priority over the +4 step, so a word
    // handshaken in the load cycle keeps the old address and the next word
    // gets addr_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= BASE_ADDR;
        end else if (addr_load) begin
            addr_q <= addr_in;
        end else if (out_hs) begin
            addr_q <= addr_q + ADDR_W'(4);
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;
    assign out_addr  = addr_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RISC-V instruction encoder; the write-side counterpart of the immediate extend unit.
- Accepts decoded fields (opcode, funct3, register indices, sign-extended 32-bit immediate, immsrc format code) and packs them into a 32-bit instruction word.
- Tags each word with a sequential byte address for loading into instruction memory.
- Sits between the test/program-load front end and imem write port; 2-stage valid/ready pipeline.

Parameters:
ADDR_W, 32, width of out_addr.
BASE_ADDR, 32'h0000_0000, out_addr value after reset (low 2 bits must be 0).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
flush  input  1  synchronous pipeline clear; does not touch address counter.
in_valid  input  1  input fields valid.
in_ready  output  1  encoder can accept.
immsrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U; 101-111 illegal.
imm  input  32  sign-extended immediate (U: full 32-bit value).
opcode  input  7  instr[6:0].
funct3  input  3  instr[14:12] (I/S/B only).
rd, rs1, rs2  input  5 each  register indices.
addr_load  input  1  load address counter.
addr_in  input  ADDR_W  load value.
out_valid  output  1  out_instr/out_addr/out_err valid.
out_ready  input  1  consumer accepts.
out_instr  output  32  encoded instruction.
out_addr  output  ADDR_W  byte address for out_instr.
out_err  output  1  immediate not representable or illegal immsrc.

Behaviour:
- Reset: in_ready=0 during reset cycle, then 1; out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR.
- Stage 1 registers accepted fields. Stage 2 registers the encoded word plus error flag.
- Accept = in_valid && in_ready. in_ready = !s1_valid || s1 advancing; s1 advances when !s2_valid || (out_valid && out_ready).
- Latency: fields accepted at edge k give out_valid high after edge k+2 with no back-pressure. Throughput is 1/cycle.
- No loss or duplication under back-pressure; order preserved. out_* are held stable while out_valid && !out_ready.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - U: {imm[31:12], rd, opcode}
  - Unused fields are ignored.
- Illegal immsrc: out_instr=32'h0000_0013 (nop), out_err=1 regardless of the optional feature.
- Address counter: out_addr is the current counter value, presented alongside out_instr. It advances by 4 on each output handshake and wraps modulo 2^ADDR_W.
- addr_load: counter<=addr_in. If a handshake occurs in the same cycle, the handshaken word used the old address and the load wins (counter=addr_in, not +4).
- flush: s1_valid and s2_valid are cleared next edge; an input offered in the flush cycle is dropped (in_ready may be 1, data discarded). Counter is unchanged.
- Reset asserted mid-stream: all in-flight words are discarded and every output returns to its reset value.

Optional Feature:
Macro IMM_RANGE_CHECK_EN.
- Defined:
  - out_err=1 if the immediate is not exactly encodable. Limits: I/S outside [-2048, 2047]; B outside [-4096, 4094] or imm[0]!=0; J outside [-2^20, 2^20-2] or imm[0]!=0; U imm[11:0]!=0.
  - The word is still emitted with truncated bits per the packing rules.
- Undefined: out_err asserts only for illegal immsrc; no range logic is synthesized.

Test Plan:
1. I addi: immsrc=000, opcode=7'h13, funct3=0, rd=1, rs1=0, imm=5 -> out_instr=32'h0050_0093, out_addr=0, out_err=0, out_valid 2 edges after accept.
2. S then J then U back-to-back with out_ready=1:
   - sw x2,8(x3): opcode=7'h23, funct3=2, imm=8 -> 32'h0021_A423 @0.
   - jal x1,8: opcode=7'h6F -> 32'h0080_00EF @4.
   - lui x5 with imm=32'h1234_5000: opcode=7'h37 -> 32'h1234_52B7 @8.
3. Back-pressure: out_ready=0 while offering 3 words -> exactly 2 accepted and in_ready falls. Raise out_ready -> 3 words out in order, addresses 0,4,8.
4. Range check (macro defined): I imm=2048 -> out_err=1. B imm=6 accepted, B imm=7 -> out_err=1. Macro undefined: both give out_err=0. immsrc=3'b111 -> 32'h0000_0013, out_err=1.
5. addr_load with addr_in=32'h100 in the same cycle as a handshake at addr 8 -> that word tagged 8, next word tagged 32'h100.
6. flush with 2 words in flight -> out_valid=0 next cycle, no stale output, next word tagged with the unchanged counter. Reset mid-stream -> out_valid=0, out_addr=BASE_ADDR.
